// File: rtl/alsu_cmd_driver.sv
// Drives packed ALSU commands onto the ALSU pins and returns each result,
// tagged and in issue order, through a first-word fall-through response FIFO.
module alsu_cmd_driver #(
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [21:0]      cmd_data,
  output logic [5:0]       A,
  output logic [5:0]       B,
  output logic [2:0]       opcode,
  output logic             cin,
  output logic             serial_in,
  output logic             direction,
  output logic             red_op_A,
  output logic             red_op_B,
  output logic             bypass_A,
  output logic             bypass_B,
  input  logic [5:0]       alsu_out,
  input  logic [15:0]      alsu_leds,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_out,
  output logic [15:0]      rsp_leds,
  output logic             rsp_invalid,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W+1)'(RSP_DEPTH);

  // Both streams: a word transfers on a rising edge where valid && ready;
  // valid never depends on ready, and data is held stable while valid is high.
  logic       accept;
  logic       capture;
  logic       pop;
  logic [2:0] cmd_op;
  logic       cmd_inv;

  logic [TAG_W-1:0] tag_cnt;
  logic             sr_valid [LATENCY];
  logic [TAG_W-1:0] sr_tag   [LATENCY];
  logic             sr_inv   [LATENCY];

  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   occupancy;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [5:0]       mem_out  [RSP_DEPTH];
  logic [15:0]      mem_leds [RSP_DEPTH];
  logic             mem_inv  [RSP_DEPTH];
  logic [TAG_W-1:0] mem_tag  [RSP_DEPTH];

  assign cmd_op  = cmd_data[9:7];
  assign cmd_inv = ((cmd_data[3] | cmd_data[2]) & (cmd_op[1] | cmd_op[2]))
                 | (cmd_op[1] & cmd_op[2]);

  // Credits cover in-flight and stored results, so a capture always finds room.
  assign occupancy = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign cmd_ready = !rst && (occupancy < OCC_LIMIT);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = sr_valid[LATENCY-1];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A         <= '0;
      B         <= '0;
      opcode    <= '0;
      cin       <= 1'b0;
      serial_in <= 1'b0;
      direction <= 1'b0;
      red_op_A  <= 1'b0;
      red_op_B  <= 1'b0;
      bypass_A  <= 1'b0;
      bypass_B  <= 1'b0;
      tag_cnt   <= '0;
    end else if (accept) begin
      A         <= cmd_data[21:16];
      B         <= cmd_data[15:10];
      opcode    <= cmd_op;
      cin       <= cmd_data[6];
      serial_in <= cmd_data[5];
      direction <= cmd_data[4];
      red_op_A  <= cmd_data[3];
      red_op_B  <= cmd_data[2];
      bypass_A  <= cmd_data[1];
      bypass_B  <= cmd_data[0];
      tag_cnt   <= tag_cnt + TAG_W'(1);
    end
  end

  // Stage 0 is loaded on the same edge as the pins; the last stage marks the
  // edge at which that command's result is sampled from the ALSU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        sr_valid[i] <= 1'b0;
        sr_tag[i]   <= '0;
        sr_inv[i]   <= 1'b0;
      end
    end else begin
      sr_valid[0] <= accept;
      sr_tag[0]   <= tag_cnt;
      sr_inv[0]   <= cmd_inv;
      for (int i = 1; i < LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_tag[i]   <= sr_tag[i-1];
        sr_inv[i]   <= sr_inv[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      inflight_cnt <= inflight_cnt + CNT_W'(accept) - CNT_W'(capture);
      fifo_cnt     <= fifo_cnt + CNT_W'(capture) - CNT_W'(pop);
      if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Pointers wrap naturally because RSP_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_out[wr_ptr]  <= alsu_out;
      mem_leds[wr_ptr] <= alsu_leds;
      mem_inv[wr_ptr]  <= sr_inv[LATENCY-1];
      mem_tag[wr_ptr]  <= sr_tag[LATENCY-1];
    end
  end

  assign rsp_out     = rsp_valid ? mem_out[rd_ptr]  : '0;
  assign rsp_leds    = rsp_valid ? mem_leds[rd_ptr] : '0;
  assign rsp_invalid = rsp_valid ? mem_inv[rd_ptr]  : 1'b0;
  assign rsp_tag     = rsp_valid ? mem_tag[rd_ptr]  : '0;

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Directed bench for alsu_cmd_driver with a small registered ALSU stand-in
// on the drive pins; expected responses are hand-computed constants.
module tb_alsu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [21:0] cmd_data = '0;
  logic [5:0]  A, B;
  logic [2:0]  opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  rsp_out;
  logic [15:0] rsp_leds;
  logic        rsp_invalid;
  logic [3:0]  rsp_tag;

  int checks   = 0;
  int failures = 0;

  // Expected {tag, out} pairs for streaming scenarios.
  logic [9:0] exp_q[$];

  alsu_cmd_driver #(.LATENCY(2), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid), .rsp_tag(rsp_tag)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // ALSU stand-in: the driver's pin register acts as the ALSU input stage,
  // this block is the output register.
  logic signed [11:0] m_prod;
  logic               m_inv;
  assign m_prod = $signed(A) * $signed(B);
  assign m_inv  = ((red_op_A | red_op_B) & (opcode[1] | opcode[2])) | (opcode[1] & opcode[2]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_out  <= '0;
      alsu_leds <= '0;
    end else if (m_inv) begin
      alsu_out  <= '0;
      alsu_leds <= ~alsu_leds;
    end else begin
      alsu_leds <= '0;
      case (opcode)
        3'd0: alsu_out <= A | B;
        3'd1: alsu_out <= A ^ B;
        3'd2: alsu_out <= A + B + {5'b0, cin};
        3'd3: alsu_out <= m_prod[5:0];
        3'd4: alsu_out <= direction ? {alsu_out[4:0], serial_in} : {serial_in, alsu_out[5:1]};
        3'd5: alsu_out <= direction ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
        default: alsu_out <= '0;
      endcase
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] pack(input logic [5:0] a, input logic [5:0] b,
                                       input logic [2:0] op, input logic c, input logic ra);
    return {a, b, op, c, 1'b0, 1'b0, ra, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_data = '0;
    tick();
    tick();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_pins", {A, B, opcode, cin}, 32'd0);
    check("rst_rsp_fields", {rsp_out, rsp_leds, rsp_invalid, rsp_tag}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic send(input logic [21:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data = d;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [5:0] e_out, input logic [15:0] e_leds,
                            input logic e_inv, input logic [3:0] e_tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({name, "_out"}, {26'b0, rsp_out}, {26'b0, e_out});
    check({name, "_leds"}, {16'b0, rsp_leds}, {16'b0, e_leds});
    check({name, "_inv"}, {31'b0, rsp_invalid}, {31'b0, e_inv});
    check({name, "_tag"}, {28'b0, rsp_tag}, {28'b0, e_tag});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int got;
    int stale;
    int rsp_cyc[$];
    logic [9:0] e;

    // Single add, with latency and pin-hold checks
    do_reset();
    cmd_valid = 1'b1;
    cmd_data = pack(6'd5, 6'd3, 3'd2, 1'b1, 1'b0);
    check("t1_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("t1_pins", {20'b0, A, B}, {20'b0, 6'd5, 6'd3});
    check("t1_op_cin", {28'b0, opcode, cin}, {28'b0, 3'd2, 1'b1});
    check("t1_lat1_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("t1_lat2_valid", {31'b0, rsp_valid}, 32'd0);
    check("t1_pins_hold", {26'b0, A}, 32'd5);
    tick();
    check("t1_lat3_valid", {31'b0, rsp_valid}, 32'd1);
    expect_rsp("add", 6'd9, 16'h0000, 1'b0, 4'd0);
    check("t1_drained", {31'b0, rsp_valid}, 32'd0);

    // Signed multiply, invalid opcode, following OR, red_op invalid
    send(pack(6'h3D, 6'd2, 3'd3, 1'b0, 1'b0));
    expect_rsp("mul", 6'h3A, 16'h0000, 1'b0, 4'd1);
    send(pack(6'd1, 6'd2, 3'd6, 1'b0, 1'b0));
    send(pack(6'd1, 6'd2, 3'd0, 1'b0, 1'b0));
    expect_rsp("inv6", 6'd0, 16'hFFFF, 1'b1, 4'd2);
    expect_rsp("or", 6'd3, 16'h0000, 1'b0, 4'd3);
    send(pack(6'd1, 6'd2, 3'd2, 1'b0, 1'b1));
    expect_rsp("redinv", 6'd0, 16'hFFFF, 1'b1, 4'd4);

    // Four back-to-back commands with the consumer always ready
    do_reset();
    rsp_ready = 1'b1;
    exp_q = '{{4'd0, 6'd1}, {4'd1, 6'd3}, {4'd2, 6'd5}, {4'd3, 6'd7}};
    for (int c = 0; c < 9; c++) begin
      cmd_valid = (c < 4);
      cmd_data = pack(6'(c + 1), 6'(c), 3'd2, 1'b0, 1'b0);
      if (c < 4) check("b2b_ready", {31'b0, cmd_ready}, 32'd1);
      if (rsp_valid) begin
        rsp_cyc.push_back(c);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        check("b2b_rsp", {22'b0, rsp_tag, rsp_out}, {22'b0, e});
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_count", rsp_cyc.size(), 32'd4);
    check("b2b_first_cycle", (rsp_cyc.size() > 0) ? rsp_cyc[0] : -1, 32'd3);
    check("b2b_last_cycle", (rsp_cyc.size() > 3) ? rsp_cyc[3] : -1, 32'd6);

    // Back-pressure: credits run out at RSP_DEPTH, then drain in order
    do_reset();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = (acc < 6);
      cmd_data = pack(6'(acc), 6'd1, 3'd2, 1'b0, 1'b0);
      if (cmd_valid && cmd_ready) acc++;
      tick();
    end
    check("bp_accepted", acc, 32'd4);
    check("bp_ready_low", {31'b0, cmd_ready}, 32'd0);
    check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    exp_q = '{{4'd0, 6'd1}, {4'd1, 6'd2}, {4'd2, 6'd3}, {4'd3, 6'd4}, {4'd4, 6'd5}, {4'd5, 6'd6}};
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      cmd_valid = (acc < 6);
      cmd_data = pack(6'(acc), 6'd1, 3'd2, 1'b0, 1'b0);
      if (cmd_valid && cmd_ready) acc++;
      if (rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        check("bp_rsp", {22'b0, rsp_tag, rsp_out}, {22'b0, e});
        got++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("bp_total_rsp", got, 32'd6);
    check("bp_total_acc", acc, 32'd6);
    tick();
    check("bp_no_extra", {31'b0, rsp_valid}, 32'd0);

    // Reset with two commands in flight
    do_reset();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = pack(6'd7, 6'd1, 3'd2, 1'b0, 1'b0);
    tick();
    cmd_data = pack(6'd8, 6'd1, 3'd2, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_pins", {A, B, opcode, cin}, 32'd0);
    check("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
    tick();
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) stale++;
      tick();
    end
    check("mid_rst_no_stale", stale, 32'd0);
    send(pack(6'd2, 6'd2, 3'd2, 1'b0, 1'b0));
    rsp_ready = 1'b0;
    expect_rsp("post_rst", 6'd4, 16'h0000, 1'b0, 4'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_driver.md
Name: alsu_cmd_driver

Overview:
- Initiator-side companion to the ALSU datapath: accepts packed ALSU commands over a valid/ready stream and drives them onto the ALSU input pins, one per cycle.
- Tracks each command through the ALSU's fixed pipeline latency, captures the resulting out/leds values and returns them in issue order over a valid/ready response stream.
- Sits between the test/firmware command source and the ALSU instance; shares clk/rst with the ALSU.

Parameters:
- LATENCY, 2, rising edges from a command appearing on the drive pins to its result being valid on alsu_out (ALSU input register plus output register).
- RSP_DEPTH, 4, entries in the response FIFO; also the credit limit on in-flight plus stored results (power of two, >= LATENCY).
- TAG_W, 4, width of the per-command sequence tag.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command word present.
- cmd_ready  out  1  driver accepts the command this cycle.
- cmd_data  in  22  {A[5:0], B[5:0], opcode[2:0], cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}, with A at the MSBs.
- A, B  out  6 each  drive pins to the ALSU, signed.
- opcode  out  3  drive pin to the ALSU.
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  out  1 each  drive pins to the ALSU.
- alsu_out  in  6  ALSU out.
- alsu_leds  in  16  ALSU leds.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_out  out  6  captured alsu_out.
- rsp_leds  out  16  captured alsu_leds.
- rsp_invalid  out  1  the command met the ALSU invalid rule.
- rsp_tag  out  TAG_W  sequence tag of the command.

Behaviour:
- Accept: a command is accepted when cmd_valid && cmd_ready at a rising edge.
- Drive: all drive pins are registered. On an accepted command, the fields are loaded at that edge. With no accepted command, the pins hold their last values and no response is generated for those cycles.
- Tag counter: starts at 0 after reset and increments by 1 per accepted command, wrapping at 2^TAG_W.
- In-flight tracking: a LATENCY-stage shift register carries {valid, tag, invalid} per command. A command loaded at edge t is captured from alsu_out/alsu_leds at edge t+LATENCY and written into the response FIFO.
- Invalid predicate, computed from the command fields: invalid = ((red_op_A|red_op_B) & (opcode[1]|opcode[2])) | (opcode[1] & opcode[2]).
- Credits: occupancy = in-flight valid entries + FIFO entries. cmd_ready = (occupancy + (pending capture this cycle ? 0 : 0)) < RSP_DEPTH, computed combinationally from registered counts. The FIFO can therefore never overflow.
- Simultaneous accept, capture and pop in one cycle: every counter update is consistent, and occupancy changes by (accept − pop).
- Response FIFO: first-word fall-through. rsp_valid = !empty. A pop happens on rsp_valid && rsp_ready. Pointers wrap modulo RSP_DEPTH. With full and empty simultaneously impossible, a push into an empty FIFO is visible on the next cycle.
- Order: responses are strictly in issue order, and tags on rsp_tag increase by 1 modulo 2^TAG_W.
- Reset, async assertion:
  - All drive pins 0.
  - Tag 0.
  - Shift register cleared.
  - FIFO empty; rsp_valid = 0; rsp_out/rsp_leds/rsp_invalid/rsp_tag = 0.
  - cmd_ready = 0 while rst is high, and 1 from the first cycle after deassertion.
- Reset mid-operation: in-flight and stored results are discarded, with no partial responses after release.
- Back-pressure: while rsp_ready is low, the FIFO fills and cmd_ready drops once credits are exhausted. No result is lost or duplicated.
- Shift/rotate commands (opcodes 4/5) depend on the ALSU's previous out. The driver does not reorder or insert cycles, so the results reflect the exact command sequence.

Test Plan:
- Reset, then one command A=5, B=3, opcode=2, cin=1, no bypass -> after LATENCY edges, a response rsp_out=6'd9, rsp_invalid=0, rsp_tag=0, rsp_leds=0.
- A=−3, B=2, opcode=3 -> rsp_out=6'h3A (−6), rsp_invalid=0.
- Opcode=6 with leds initially 0 -> rsp_out=0, rsp_invalid=1, rsp_leds=16'hFFFF. A following valid OR command (A=1, B=2) -> rsp_out=3, rsp_leds=0.
- Four back-to-back commands with rsp_ready=1 -> four responses on consecutive cycles with tags 0,1,2,3 in order. cmd_ready stays 1 throughout.
- rsp_ready=0 and 6 commands offered -> exactly RSP_DEPTH=4 accepted, then cmd_ready=0. Raising rsp_ready drains 4 responses in order, and the remaining 2 are then accepted with tags 4 and 5.
- Assert rst while 2 commands are in flight -> rsp_valid=0 and drive pins 0 immediately. After release, no stale responses appear and the next command returns tag 0.
